// File: rtl/seq_detector_pkg.sv
// Shared constants and width helpers for the parametrised serial-pattern detector.
package seq_detector_pkg;

  localparam logic [3:0] PAT_1011  = 4'b1011;
  localparam logic [1:0] PAT_10    = 2'b10;
  localparam int         MAX_PAT_W = 16;

  // Widest state any legal PAT_W can need.
  typedef logic [$clog2(MAX_PAT_W)-1:0] max_state_t;

  function automatic int state_w(input int pat_w);
    return (pat_w < 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/seq_detector_param_prefix_calc.sv
// Combinational prefix search: next matched-prefix length and raw match flag
// from the loaded pattern, recent history, the incoming bit and current state.
module seq_prefix_calc
  import seq_detector_pkg::*;
#(
  parameter int PAT_W   = 4,
  parameter bit OVERLAP = 1'b1,
  localparam int STATE_W = state_w(PAT_W)
) (
  input  logic [PAT_W-1:0]   pat_reg,
  input  logic [PAT_W-2:0]   history,
  input  logic               x,
  input  logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] next_state,
  output logic               match
);

  logic [PAT_W-1:0] window;
  logic             hit;

  // window[0] is the incoming bit, window[j] the bit received j accepts earlier.
  assign window = {history, x};

  // A full prefix guarantees every history bit is a genuinely accepted bit.
  assign match = (int'(state) == PAT_W - 1) && (window == pat_reg);

  // A new prefix can never be longer than the old one plus the incoming bit,
  // which also keeps stale history bits out of the search.
  always_comb begin
    next_state = '0;
    hit        = 1'b0;
    for (int k = 1; k < PAT_W; k++) begin
      hit = (k <= int'(state) + 1);
      for (int j = 0; j < k; j++) begin
        if (window[j] != pat_reg[PAT_W-k+j]) hit = 1'b0;
      end
      if (hit) next_state = STATE_W'(k);
    end
    if (match && !OVERLAP) next_state = '0;
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with runtime-loadable pattern.
// Optional saturating match counter enabled by SEQDET_MATCH_CNT_EN.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PAT_1011),
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8,
  localparam int              STATE_W = state_w(PAT_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               x,
  input  logic               pat_load,
  input  logic [PAT_W-1:0]   pat_in,
  output logic               match,
  output logic               match_q,
  output logic [STATE_W-1:0] state
`ifdef SEQDET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]   match_count
`endif
);

  if (PAT_W < 2 || PAT_W > MAX_PAT_W || CNT_W < 1) begin : g_bad_params
    $error("seq_detector_param: unsupported PAT_W or CNT_W");
  end

  logic [PAT_W-1:0]   pat_reg;
  logic [PAT_W-2:0]   history;
  logic [STATE_W-1:0] next_state;
  logic               raw_match;

  seq_prefix_calc #(
    .PAT_W   (PAT_W),
    .OVERLAP (OVERLAP)
  ) u_prefix_calc (
    .pat_reg    (pat_reg),
    .history    (history),
    .x          (x),
    .state      (state),
    .next_state (next_state),
    .match      (raw_match)
  );

  // Handshake: a bit is accepted only at an edge with in_valid=1 and
  // pat_load=0; pat_load wins and the bit presented that cycle is dropped.
  assign match = in_valid & ~pat_load & raw_match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_reg <= PATTERN;
      state   <= '0;
      history <= '0;
      match_q <= 1'b0;
    end else begin
      match_q <= match;
      if (pat_load) begin
        pat_reg <= pat_in;
        state   <= '0;
        history <= '0;
      end else if (in_valid) begin
        state   <= next_state;
        history <= (PAT_W-1)'({history, x});
      end
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_count <= '0;
    end else if (pat_load) begin
      match_count <= '0;
    end else if (match && (match_count != '1)) begin
      match_count <= match_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: three detector configurations driven in lockstep and
// compared against a stream-history reference model.
module tb_seq_detector_param;
  import seq_detector_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, x;
  logic       pat_load_a, pat_load_b, pat_load_c;
  logic [3:0] pat_in_a, pat_in_b;
  logic [1:0] pat_in_c;
  logic       match_a, match_b, match_c;
  logic       match_q_a, match_q_b, match_q_c;
  logic [1:0] state_a, state_b;
  logic [0:0] state_c;
`ifdef SEQDET_MATCH_CNT_EN
  logic [1:0] match_count_a;
  logic [7:0] match_count_b, match_count_c;
`endif

  int tests_run = 0;
  int failures  = 0;
  int hits[3];

  // Reference model: last accepted bits (newest at bit 0) since reset/load/restart.
  logic [15:0] m_hist[3];
  logic [15:0] m_pat[3];
  int          m_len[3];
  int          m_cnt[3];
  int          m_w[3]    = '{4, 4, 2};
  bit          m_ovl[3]  = '{1'b1, 1'b0, 1'b1};
  int          m_cmax[3] = '{3, 255, 255};

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .PATTERN(PAT_1011), .OVERLAP(1'b1), .CNT_W(2)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .pat_load(pat_load_a),
    .pat_in(pat_in_a), .match(match_a), .match_q(match_q_a), .state(state_a)
`ifdef SEQDET_MATCH_CNT_EN
    , .match_count(match_count_a)
`endif
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(PAT_1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .pat_load(pat_load_b),
    .pat_in(pat_in_b), .match(match_b), .match_q(match_q_b), .state(state_b)
`ifdef SEQDET_MATCH_CNT_EN
    , .match_count(match_count_b)
`endif
  );

  seq_detector_param #(.PAT_W(2), .PATTERN(PAT_10), .OVERLAP(1'b1), .CNT_W(8)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .pat_load(pat_load_c),
    .pat_in(pat_in_c), .match(match_c), .match_q(match_q_c), .state(state_c)
`ifdef SEQDET_MATCH_CNT_EN
    , .match_count(match_count_c)
`endif
  );

  // Longest k<=max_k such that the last k accepted bits equal the first k pattern bits.
  function automatic int longest(input int d, input int max_k);
    bit ok;
    for (int k = max_k; k >= 1; k--) begin
      if (m_len[d] >= k) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (m_hist[d][k-1-i] != m_pat[d][m_w[d]-1-i]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pat[0] = 16'(PAT_1011);
    m_pat[1] = 16'(PAT_1011);
    m_pat[2] = 16'(PAT_10);
    for (int d = 0; d < 3; d++) begin
      m_hist[d] = '0; m_len[d] = 0; m_cnt[d] = 0; hits[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input bit v, input bit xb, input bit ld,
                            input logic [15:0] pin, output bit em, output int es);
    em = 1'b0;
    if (ld) begin
      m_pat[d] = pin; m_hist[d] = '0; m_len[d] = 0; m_cnt[d] = 0;
    end else if (v) begin
      m_hist[d] = {m_hist[d][14:0], xb};
      if (m_len[d] < 16) m_len[d]++;
      em = (longest(d, m_w[d]) == m_w[d]);
      if (em) begin
        if (m_cnt[d] < m_cmax[d]) m_cnt[d]++;
        if (!m_ovl[d]) begin m_hist[d] = '0; m_len[d] = 0; end
      end
    end
    es = longest(d, m_w[d] - 1);
  endtask

  // One clock cycle; called and returns just after a rising edge.
  task automatic drive(input bit v, input bit xb,
                       input bit la = 0, input logic [3:0] pa = '0,
                       input bit lb = 0, input logic [3:0] pb = '0,
                       input bit lc = 0, input logic [1:0] pc = '0);
    bit         em[3];
    int         es[3];
    logic [2:0] mo;
    logic [3:0] so[3];
    in_valid = v; x = xb;
    pat_load_a = la; pat_in_a = pa;
    pat_load_b = lb; pat_in_b = pb;
    pat_load_c = lc; pat_in_c = pc;
    model_step(0, v, xb, la, 16'(pa), em[0], es[0]);
    model_step(1, v, xb, lb, 16'(pb), em[1], es[1]);
    model_step(2, v, xb, lc, 16'(pc), em[2], es[2]);
    @(negedge clk);
    mo = {match_c, match_b, match_a};
    for (int d = 0; d < 3; d++) begin
      tests_run++;
      if (mo[d] !== em[d]) begin
        failures++;
        $display("FAIL match dut%0d t=%0t: got %b expected %b", d, $time, mo[d], em[d]);
      end
      if (mo[d] === 1'b1) hits[d]++;
    end
    @(posedge clk); #1;
    mo = {match_q_c, match_q_b, match_q_a};
    so[0] = {2'b00, state_a}; so[1] = {2'b00, state_b}; so[2] = {3'b000, state_c};
    for (int d = 0; d < 3; d++) begin
      tests_run += 2;
      if (mo[d] !== em[d]) begin
        failures++;
        $display("FAIL match_q dut%0d t=%0t: got %b expected %b", d, $time, mo[d], em[d]);
      end
      if (so[d] !== 4'(es[d])) begin
        failures++;
        $display("FAIL state dut%0d t=%0t: got %0d expected %0d", d, $time, so[d], es[d]);
      end
    end
`ifdef SEQDET_MATCH_CNT_EN
    tests_run++;
    if (match_count_a !== 2'(m_cnt[0]) || match_count_b !== 8'(m_cnt[1]) ||
        match_count_c !== 8'(m_cnt[2])) begin
      failures++;
      $display("FAIL match_count t=%0t: got %0d/%0d/%0d expected %0d/%0d/%0d", $time,
               match_count_a, match_count_b, match_count_c, m_cnt[0], m_cnt[1], m_cnt[2]);
    end
`endif
  endtask

  task automatic drive_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, bits[i]);
  endtask

  task automatic apply_reset();
    reset = 1'b1; in_valid = 1'b0; x = 1'b0;
    pat_load_a = 1'b0; pat_load_b = 1'b0; pat_load_c = 1'b0;
    pat_in_a = '0; pat_in_b = '0; pat_in_c = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    reset = 1'b1; #1;
    tests_run++;
    if ({match_a, match_b, match_c, match_q_a, match_q_b, match_q_c} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000000",
               {match_a, match_b, match_c, match_q_a, match_q_b, match_q_c});
    end
    tests_run++;
    if ({state_a, state_b, state_c} !== 5'b0) begin
      failures++;
      $display("FAIL reset_state: got %b expected 00000", {state_a, state_b, state_c});
    end
    reset = 1'b0;
  endtask

  task automatic test_overlap();
    apply_reset();
    drive_bits(16'b1011011, 7);
    tests_run++;
    if (hits[0] != 2 || state_a !== 2'd1) begin
      failures++;
      $display("FAIL overlap_a: got hits %0d state %0d expected hits 2 state 1", hits[0], state_a);
    end
    tests_run++;
    if (hits[1] != 1) begin
      failures++;
      $display("FAIL no_overlap_b: got hits %0d expected 1", hits[1]);
    end
    drive_bits(16'b011, 3);
    tests_run++;
    if (hits[1] != 2) begin
      failures++;
      $display("FAIL no_overlap_b_cont: got hits %0d expected 2", hits[1]);
    end
  endtask

  task automatic test_gaps();
    apply_reset();
    drive(1'b1, 1'b1); drive(1'b1, 1'b0);
    drive(1'b0, 1'b1); drive(1'b0, 1'b0); drive(1'b0, 1'b1);
    tests_run++;
    if (state_a !== 2'd2) begin
      failures++;
      $display("FAIL gap_state: got %0d expected 2", state_a);
    end
    drive(1'b1, 1'b1); drive(1'b1, 1'b1);
    tests_run++;
    if (hits[0] != 1) begin
      failures++;
      $display("FAIL gap_hits: got %0d expected 1", hits[0]);
    end
  endtask

  task automatic test_pat_load();
    apply_reset();
    drive_bits(16'b101, 3);
    drive(1'b1, 1'b1, 1'b1, 4'b1100);
    tests_run++;
    if (state_a !== 2'd0) begin
      failures++;
      $display("FAIL load_state: got %0d expected 0", state_a);
    end
    drive_bits(16'b1100, 4);
    tests_run++;
    if (hits[0] != 1) begin
      failures++;
      $display("FAIL load_hits: got %0d expected 1", hits[0]);
    end
  endtask

  task automatic test_legacy();
    apply_reset();
    drive_bits(16'b011100, 6);
    tests_run++;
    if (hits[2] != 1) begin
      failures++;
      $display("FAIL legacy_hits: got %0d expected 1", hits[2]);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive_bits(16'b101, 3);
    in_valid = 1'b1; x = 1'b1; #1;
    tests_run++;
    if (match_a !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_match: got %b expected 1", match_a);
    end
    reset = 1'b1; #1;
    tests_run++;
    if (state_a !== 2'd0 || match_a !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got state %0d match %b expected 0 0", state_a, match_a);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 24) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 24) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 24) == 0), 2'($urandom_range(0, 3)));
    end
  endtask

`ifdef SEQDET_MATCH_CNT_EN
  task automatic test_saturate();
    apply_reset();
    drive_bits(16'b1011011011011011, 16);
    tests_run++;
    if (hits[0] != 5 || match_count_a !== 2'd3) begin
      failures++;
      $display("FAIL saturate: got hits %0d count %0d expected 5 3", hits[0], match_count_a);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_overlap();
    test_gaps();
    test_pat_load();
    test_legacy();
    test_async_reset();
    test_random();
`ifdef SEQDET_MATCH_CNT_EN
    test_saturate();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
